key_onehot_capture: RTL and testbench
=====================================

# key_onehot_capture

Upstream input stage for the 4-to-2 encoder. It takes four raw, bouncy key/request lines, synchronises and debounces each one, and locks onto a single key. It drives a registered, strictly one-hot `Y3..Y0` plus `en`, so the downstream encoder never sees zero-hot-with-enable or multi-hot inputs.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronised input must differ from its debounced value before that value flips. Legal range is 1 to 65535.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width. Derived; not overridden.

Ports:
- `clk`  in  1  single clock; all flops are rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key3`, `key2`, `key1`, `key0`  in  1 each  raw asynchronous key/request lines, active-high.
- `Y3`, `Y2`, `Y1`, `Y0`  out  1 each  registered one-hot code of the locked key. All zero when no key is locked.
- `en`  out  1  registered; high exactly when one `Y` bit is high. Drives the encoder enable.
- `press`  out  1  registered one-cycle pulse on the cycle `en` first rises for a new lock.

## Operation
- **Per-key input path:**
  - 2-flop synchroniser, then a debouncer: debounced bit `stable[i]` plus counter `cnt[i]`.
  - If `sync[i] == stable[i]`, `cnt[i]` clears to 0.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`, `stable[i]` toggles and `cnt[i]` clears.
  - Else `cnt[i]` increments.
  - A pulse shorter than `DEBOUNCE_CYCLES` synchronised cycles is rejected.
- **FSM states:** IDLE, LOCKED, WAIT_REL. State and outputs are registered.
  - **IDLE:** `Y=0000`, `en=0`. If any `stable[i]` is 1, lock index L = highest set index (key3 > key2 > key1 > key0). Next state is LOCKED; next `Y` = one-hot(L), `en=1`, `press=1`.
  - **LOCKED:** hold `Y`/`en`; `press=0`. When `stable[L]` falls to 0, go to WAIT_REL with `Y=0000`, `en=0`. Other keys pressing or releasing while LOCKED are ignored.
  - **WAIT_REL:** `Y=0000`, `en=0`. Stay until all `stable` bits are 0, then go to IDLE. This prevents rollover into a second key without a full release.
- **Invariant, every cycle:** `en == (Y3|Y2|Y1|Y0)`, at most one `Y` bit is set, and `press` implies `en`.
- **Reset:** `rst_n` low clears synchronisers, `stable`, `cnt`, and state (to IDLE) immediately and asynchronously.
  - Outputs reset to `Y=0000`, `en=0`, `press=0`.
  - Reset mid-lock drops outputs at once.
  - After release with a key still held, the full sync + debounce latency applies again before a lock.

## Timing
- **Press latency:** number sampling edges with edge 1 = first rising edge at which the raw key is sampled high and stays high.
  - Synchroniser output is high after edge 2.
  - `stable` flips after edge 2+D (D = `DEBOUNCE_CYCLES`).
  - `Y`/`en`/`press` rise after edge 3+D.
  - `press` falls after edge 4+D.
- **Release latency:** from the first low-sampled edge to `en` falling is also 3+D edges.
- **Re-press:** a new lock needs at least one IDLE cycle. From WAIT_REL, IDLE is entered 1 edge after the last `stable` bit clears, and a lock can be taken 1 edge later.
- **Simultaneous press:** if several `stable` bits rise in the same cycle in IDLE, the highest index wins.
- **Asynchronous inputs:** no timing requirement; metastability is handled by the synchroniser only.

## Test plan
1. **Reset:** hold `rst_n=0` with key2 high for 10 cycles.
   - During reset: `Y=0000`, `en=0`, `press=0`.
   - After release, with D=4: `Y=0100`, `en=1` after the 7th edge; `press` is high for that one cycle only.
2. **Glitch reject and debounce:** D=4.
   - key0 high for 3 cycles: no output change.
   - key0 high for 4 or more cycles: `Y=0001`, `en=1` on edge 7 counted from the first high sample.
3. **Priority:** key1 and key3 go high on the same edge → `Y=1000` only. Then drop key3 while holding key1 → `Y=0000`, `en=0`, state WAIT_REL. `Y` stays 0000 until key1 is also released and debounced.
4. **Lock holding:** lock key1 (`Y=0010`), then press key3 → `Y` stays 0010 and `press` stays low. Release both, then press key3 → `Y=1000` with a new `press` pulse.
5. **Reset mid-lock:** while `Y=0100`, pulse `rst_n` low for 1 cycle.
   - Outputs go to 0 asynchronously, without waiting for a clock edge.
   - With key2 still held, relock `Y=0100` 7 edges after reset deassertion.
6. **Invariant check:** drive random bouncy stimulus on all keys for 10k cycles. Every cycle: `Y` is at most one-hot, `en == OR(Y)`, and `press` is never high on two consecutive cycles.

Source files
------------

// File: rtl/key_onehot_capture.sv
// Input stage for the 4-to-2 encoder: it synchronises and debounces four raw key lines,
// then locks onto one key and drives a registered one-hot Y with a matching enable.
module key_onehot_capture #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key3,
  input  logic       key2,
  input  logic       key1,
  input  logic       key0,
  output logic       Y3,
  output logic       Y2,
  output logic       Y1,
  output logic       Y0,
  output logic       en,
  output logic       press,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       w_keys;
  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_stable;
  logic [CNT_W-1:0] r_cnt [4];

  state_t     r_state;
  logic [3:0] r_y;
  logic       r_en;
  logic       r_press;
  logic [1:0] r_lock;

  logic [1:0] w_lock_idx;
  logic [3:0] w_lock_oh;

  assign w_keys = {key3, key2, key1, key0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_keys;
      r_sync2 <= r_sync1;
    end
  end

  // A key's stable bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_stable[i] <= ~r_stable[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_lock_idx = 2'd0;
    if (r_stable[3])      w_lock_idx = 2'd3;
    else if (r_stable[2]) w_lock_idx = 2'd2;
    else if (r_stable[1]) w_lock_idx = 2'd1;
    else                  w_lock_idx = 2'd0;
  end

  assign w_lock_oh = 4'b0001 << w_lock_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_y     <= '0;
      r_en    <= 1'b0;
      r_press <= 1'b0;
      r_lock  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_press <= 1'b0;
          if (|r_stable) begin
            r_state <= ST_LOCKED;
            r_y     <= w_lock_oh;
            r_en    <= 1'b1;
            r_press <= 1'b1;
            r_lock  <= w_lock_idx;
          end
        end
        ST_LOCKED: begin
          r_press <= 1'b0;
          if (!r_stable[r_lock]) begin
            r_state <= ST_WAIT_REL;
            r_y     <= '0;
            r_en    <= 1'b0;
          end
        end
        // Refuse to roll over into another key until every key is released.
        ST_WAIT_REL: begin
          r_press <= 1'b0;
          r_y     <= '0;
          r_en    <= 1'b0;
          if (r_stable == 4'b0000) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_y     <= '0;
          r_en    <= 1'b0;
          r_press <= 1'b0;
        end
      endcase
    end
  end

  assign {Y3, Y2, Y1, Y0} = r_y;
  assign en        = r_en;
  assign press     = r_press;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_key_onehot_capture.sv
// Directed bench for key_onehot_capture (DEBOUNCE_CYCLES = 4): latency, glitch rejection,
// priority, lock holding, asynchronous reset, plus a randomised invariant sweep.
module tb_key_onehot_capture;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LOCKED   = 2'd1;
  localparam logic [1:0] ST_WAIT_REL = 2'd2;

  logic       clk;
  logic       rst_n;
  logic       key3, key2, key1, key0;
  logic       Y3, Y2, Y1, Y0;
  logic       en;
  logic       press;
  logic [1:0] dbg_state;

  logic [5:0] w_out;
  logic [3:0] w_y;

  int n_pass;
  int n_total;

  key_onehot_capture #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key3      (key3),
    .key2      (key2),
    .key1      (key1),
    .key0      (key0),
    .Y3        (Y3),
    .Y2        (Y2),
    .Y1        (Y1),
    .Y0        (Y0),
    .en        (en),
    .press     (press),
    .dbg_state (dbg_state)
  );

  assign w_y   = {Y3, Y2, Y1, Y0};
  assign w_out = {Y3, Y2, Y1, Y0, en, press};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_keys(input logic [3:0] k);
    {key3, key2, key1, key0} = k;
  endtask

  task automatic do_reset();
    set_keys(4'b0000);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_keys(4'b0100);
    tick(10);
    n_total++; if (w_out !== 6'b0000_0_0) $display("FAIL reset_hold: out=%b exp=%b", w_out, 6'b000000); else n_pass++;
    n_total++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state: state=%0d exp=%0d", dbg_state, ST_IDLE); else n_pass++;
    rst_n = 1'b1;
    tick(6);
    n_total++; if (w_out !== 6'b0000_0_0) $display("FAIL reset_edge6: out=%b exp=%b", w_out, 6'b000000); else n_pass++;
    tick(1);
    n_total++; if (w_out !== 6'b0100_1_1) $display("FAIL reset_edge7: out=%b exp=%b", w_out, 6'b010011); else n_pass++;
    n_total++; if (dbg_state !== ST_LOCKED) $display("FAIL reset_locked: state=%0d exp=%0d", dbg_state, ST_LOCKED); else n_pass++;
    tick(1);
    n_total++; if (w_out !== 6'b0100_1_0) $display("FAIL reset_edge8: out=%b exp=%b", w_out, 6'b010010); else n_pass++;
  endtask

  task automatic test_glitch();
    int bad;
    do_reset();
    set_keys(4'b0001);
    tick(3);
    set_keys(4'b0000);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (w_out !== 6'b0) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL glitch_reject: bad_cycles=%0d exp=0", bad); else n_pass++;
    set_keys(4'b0001);
    tick(6);
    n_total++; if (w_out !== 6'b0000_0_0) $display("FAIL debounce_edge6: out=%b exp=%b", w_out, 6'b000000); else n_pass++;
    tick(1);
    n_total++; if (w_out !== 6'b0001_1_1) $display("FAIL debounce_edge7: out=%b exp=%b", w_out, 6'b000111); else n_pass++;
    set_keys(4'b0000);
    tick(6);
    n_total++; if (w_out !== 6'b0001_1_0) $display("FAIL release_edge6: out=%b exp=%b", w_out, 6'b000110); else n_pass++;
    tick(1);
    n_total++; if (w_out !== 6'b0000_0_0) $display("FAIL release_edge7: out=%b exp=%b", w_out, 6'b000000); else n_pass++;
    n_total++; if (dbg_state !== ST_WAIT_REL) $display("FAIL release_wait: state=%0d exp=%0d", dbg_state, ST_WAIT_REL); else n_pass++;
    tick(1);
    n_total++; if (dbg_state !== ST_IDLE) $display("FAIL release_idle: state=%0d exp=%0d", dbg_state, ST_IDLE); else n_pass++;
  endtask

  task automatic test_priority();
    int bad;
    do_reset();
    set_keys(4'b1010);
    tick(7);
    n_total++; if (w_out !== 6'b1000_1_1) $display("FAIL prio_lock: out=%b exp=%b", w_out, 6'b100011); else n_pass++;
    set_keys(4'b0010);
    tick(7);
    n_total++; if (w_out !== 6'b0000_0_0) $display("FAIL prio_drop: out=%b exp=%b", w_out, 6'b000000); else n_pass++;
    n_total++; if (dbg_state !== ST_WAIT_REL) $display("FAIL prio_wait: state=%0d exp=%0d", dbg_state, ST_WAIT_REL); else n_pass++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (w_out !== 6'b0 || dbg_state !== ST_WAIT_REL) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL prio_no_rollover: bad_cycles=%0d exp=0", bad); else n_pass++;
    set_keys(4'b0000);
    tick(6);
    n_total++; if (dbg_state !== ST_WAIT_REL) $display("FAIL prio_still_wait: state=%0d exp=%0d", dbg_state, ST_WAIT_REL); else n_pass++;
    tick(1);
    n_total++; if (dbg_state !== ST_IDLE) $display("FAIL prio_idle: state=%0d exp=%0d", dbg_state, ST_IDLE); else n_pass++;
  endtask

  task automatic test_lock_hold();
    int bad;
    do_reset();
    set_keys(4'b0010);
    tick(7);
    n_total++; if (w_out !== 6'b0010_1_1) $display("FAIL hold_lock1: out=%b exp=%b", w_out, 6'b001011); else n_pass++;
    set_keys(4'b1010);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (w_out !== 6'b0010_1_0) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL hold_ignore_key3: bad_cycles=%0d exp=0", bad); else n_pass++;
    set_keys(4'b0000);
    tick(7);
    n_total++; if (w_out !== 6'b0000_0_0) $display("FAIL hold_release: out=%b exp=%b", w_out, 6'b000000); else n_pass++;
    tick(1);
    n_total++; if (dbg_state !== ST_IDLE) $display("FAIL hold_idle: state=%0d exp=%0d", dbg_state, ST_IDLE); else n_pass++;
    set_keys(4'b1000);
    tick(6);
    n_total++; if (w_out !== 6'b0000_0_0) $display("FAIL hold_key3_edge6: out=%b exp=%b", w_out, 6'b000000); else n_pass++;
    tick(1);
    n_total++; if (w_out !== 6'b1000_1_1) $display("FAIL hold_key3_edge7: out=%b exp=%b", w_out, 6'b100011); else n_pass++;
    tick(1);
    n_total++; if (w_out !== 6'b1000_1_0) $display("FAIL hold_key3_edge8: out=%b exp=%b", w_out, 6'b100010); else n_pass++;
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    set_keys(4'b0100);
    tick(7);
    n_total++; if (w_out !== 6'b0100_1_1) $display("FAIL midrst_lock: out=%b exp=%b", w_out, 6'b010011); else n_pass++;
    tick(2);
    rst_n = 1'b0;
    #1;
    n_total++; if (w_out !== 6'b0000_0_0) $display("FAIL midrst_async: out=%b exp=%b", w_out, 6'b000000); else n_pass++;
    tick(1);
    rst_n = 1'b1;
    tick(6);
    n_total++; if (w_out !== 6'b0000_0_0) $display("FAIL midrst_edge6: out=%b exp=%b", w_out, 6'b000000); else n_pass++;
    tick(1);
    n_total++; if (w_out !== 6'b0100_1_1) $display("FAIL midrst_relock: out=%b exp=%b", w_out, 6'b010011); else n_pass++;
  endtask

  task automatic test_random_invariant();
    logic [3:0] k;
    logic       prev_press;
    int         presses;
    do_reset();
    k          = 4'b0000;
    prev_press = 1'b0;
    presses    = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 15) == 0) k[b] = ~k[b];
      set_keys(k);
      tick(1);
      n_total++;
      if ($countones(w_y) > 1 || en !== (|w_y))
        $display("FAIL inv_onehot cycle %0d: y=%b en=%b exp en=%b", c, w_y, en, |w_y);
      else n_pass++;
      n_total++;
      if (press && !en) $display("FAIL inv_press_en cycle %0d: press=%b en=%b exp en=1", c, press, en);
      else n_pass++;
      n_total++;
      if (press && prev_press) $display("FAIL inv_press_twice cycle %0d: press=%b prev=%b exp 0", c, press, prev_press);
      else n_pass++;
      if (press) presses++;
      prev_press = press;
    end
    n_total++; if (presses == 0) $display("FAIL inv_activity: presses=%0d exp >0", presses); else n_pass++;
    set_keys(4'b0000);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    set_keys(4'b0000);
    test_reset();
    test_glitch();
    test_priority();
    test_lock_hold();
    test_reset_mid_lock();
    test_random_invariant();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
